can_tx_arb_scheduler: RTL and testbench

- Transmit-side arbitration scheduler for the CAN controller.
- Picks the highest-priority pending TX mailbox, with the lowest 11-bit ID winning.
- Serialises SOF + ID + RTR onto tx_bit at bit-timing sample points and drives arbitration_active for the arbitration-loss detector.
- Reacts to won/lost outcomes: grants on a win, backs off and retries on a loss. Sits between the mailbox bank and the bit-timing/bit-stream logic.

---
 rtl/can_pkg.sv | 28 ++
 rtl/can_id_prio_sel.sv | 37 +++
 rtl/can_tx_arb_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_can_tx_arb_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN arbitration types and constants for the TX arbitration scheduler
// and its priority selector.
package can_pkg;

  localparam int   CAN_ID_W      = 11;
  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;
  localparam int   CAN_ARB_LEN   = CAN_ID_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT_IDLE,
    ST_ARB,
    ST_GRANTED,
    ST_BACKOFF
  } arb_state_e;

  // Arbitration field = SOF + identifier + RTR.
  function automatic int arb_len(input int id_w);
    return id_w + 2;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/can_id_prio_sel.sv
// Combinational priority pick over pending mailboxes: lowest identifier wins,
// equal identifiers resolve to the lowest mailbox index.
module can_id_prio_sel
  import can_pkg::*;
#(
  parameter int NUM_MB = 4,
  parameter int ID_W   = CAN_ID_W,
  localparam int IDX_W = idx_width(NUM_MB)
) (
  input  logic [NUM_MB-1:0]      req,
  input  logic [NUM_MB*ID_W-1:0] mb_id,
  input  logic [NUM_MB-1:0]      mb_rtr,
  output logic                   valid,
  output logic [IDX_W-1:0]       idx,
  output logic [ID_W-1:0]        id,
  output logic                   rtr
);

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    id    = '0;
    rtr   = 1'b0;
    // Strict less-than keeps the earlier (lower-index) mailbox on a tie.
    for (int i = 0; i < NUM_MB; i++) begin
      if (req[i] && (!valid || (mb_id[i*ID_W +: ID_W] < id))) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
        id    = mb_id[i*ID_W +: ID_W];
        rtr   = mb_rtr[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_arb_scheduler.sv
// CAN transmit arbitration scheduler: selects the highest-priority mailbox,
// serialises SOF/ID/RTR at sample points and resolves win, loss or bit error.
module can_tx_arb_scheduler
  import can_pkg::*;
#(
  parameter int NUM_MB    = 4,
  parameter int ID_W      = CAN_ID_W,
  parameter int RETRY_MAX = 16,
  localparam int IDX_W    = idx_width(NUM_MB),
  localparam int RTRY_W   = $clog2(RETRY_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MB-1:0]      req,
  input  logic [NUM_MB*ID_W-1:0] mb_id,
  input  logic [NUM_MB-1:0]      mb_rtr,
  input  logic                   sample_point,
  input  logic                   rx_bit,
  input  logic                   bus_idle,
  input  logic                   frame_done,
  output logic                   tx_bit,
  output logic                   arbitration_active,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   arb_won,
  output logic                   arb_lost,
  output logic                   bit_err,
  output logic                   give_up,
  output logic [RTRY_W-1:0]      retry_cnt
);

  localparam int ARB_LEN = arb_len(ID_W);
  localparam int CNT_W   = $clog2(ARB_LEN);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, grant_idx_q, grant_idx_d;
  logic [ID_W:0]     shift_q, shift_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              rtr_q, rtr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic              tx_bit_q, tx_bit_d, active_q, active_d, grant_q, grant_d;
  logic              won_q, won_d, lost_q, lost_d, berr_q, berr_d, give_up_q, give_up_d;

  logic              sel_valid, sel_rtr;
  logic [IDX_W-1:0]  sel_idx;
  logic [ID_W-1:0]   sel_id;

  can_id_prio_sel #(.NUM_MB(NUM_MB), .ID_W(ID_W)) u_prio_sel (
    .req    (req),
    .mb_id  (mb_id),
    .mb_rtr (mb_rtr),
    .valid  (sel_valid),
    .idx    (sel_idx),
    .id     (sel_id),
    .rtr    (sel_rtr)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    id_d        = id_q;
    rtr_d       = rtr_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    retry_d     = retry_q;
    tx_bit_d    = tx_bit_q;
    active_d    = active_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    won_d       = 1'b0;
    lost_d      = 1'b0;
    berr_d      = 1'b0;
    give_up_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (|req) state_d = ST_SELECT;
      ST_SELECT: begin
        if (sel_valid) begin
          if (sel_idx != idx_q) retry_d = '0;
          idx_d   = sel_idx;
          id_d    = sel_id;
          rtr_d   = sel_rtr;
          state_d = ST_WAIT_IDLE;
        end else begin
          retry_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!req[idx_q]) begin
          retry_d = '0;
          state_d = ST_IDLE;
        end else if (sample_point && bus_idle) begin
          // SOF goes out now; the shifter holds the remaining ID and RTR bits.
          tx_bit_d  = CAN_DOMINANT;
          active_d  = 1'b1;
          shift_d   = {id_q, rtr_q};
          bit_cnt_d = '0;
          state_d   = ST_ARB;
        end
      end
      ST_ARB: begin
        if (sample_point) begin
          if (tx_bit_q == CAN_RECESSIVE && rx_bit == CAN_DOMINANT) begin
            tx_bit_d = CAN_RECESSIVE;
            active_d = 1'b0;
            if (int'(retry_q) + 1 >= RETRY_MAX) begin
              give_up_d = 1'b1;
              retry_d   = '0;
              state_d   = ST_IDLE;
            end else begin
              lost_d  = 1'b1;
              retry_d = retry_q + 1'b1;
              state_d = ST_BACKOFF;
            end
          end else if (tx_bit_q == CAN_DOMINANT && rx_bit == CAN_RECESSIVE) begin
            berr_d   = 1'b1;
            tx_bit_d = CAN_RECESSIVE;
            active_d = 1'b0;
            state_d  = ST_BACKOFF;
          end else if (bit_cnt_q == CNT_W'(ARB_LEN - 1)) begin
            won_d       = 1'b1;
            grant_d     = 1'b1;
            grant_idx_d = idx_q;
            tx_bit_d    = CAN_RECESSIVE;
            active_d    = 1'b0;
            state_d     = ST_GRANTED;
          end else begin
            tx_bit_d  = shift_q[ID_W];
            shift_d   = {shift_q[ID_W-1:0], CAN_RECESSIVE};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_GRANTED: begin
        if (frame_done) begin
          grant_d = 1'b0;
          retry_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_BACKOFF: if (frame_done) state_d = ST_SELECT;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      id_q        <= '0;
      rtr_q       <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      retry_q     <= '0;
      tx_bit_q    <= CAN_RECESSIVE;
      active_q    <= 1'b0;
      grant_q     <= 1'b0;
      grant_idx_q <= '0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
      berr_q      <= 1'b0;
      give_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      id_q        <= id_d;
      rtr_q       <= rtr_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      retry_q     <= retry_d;
      tx_bit_q    <= tx_bit_d;
      active_q    <= active_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      won_q       <= won_d;
      lost_q      <= lost_d;
      berr_q      <= berr_d;
      give_up_q   <= give_up_d;
    end
  end

  assign tx_bit             = tx_bit_q;
  assign arbitration_active = active_q;
  assign grant_valid        = grant_q;
  assign grant_idx          = grant_idx_q;
  assign arb_won            = won_q;
  assign arb_lost           = lost_q;
  assign bit_err            = berr_q;
  assign give_up            = give_up_q;
  assign retry_cnt          = retry_q;

endmodule

// File: tb/tb_can_tx_arb_scheduler.sv
// Bench for can_tx_arb_scheduler: directed scenarios plus randomized mailbox
// contents checked against a priority/frame reference model.
module tb_can_tx_arb_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [43:0] mb_id = '0;
  logic [3:0]  mb_rtr = '0;
  logic        sample_point = 1'b0, rx_bit = 1'b1, bus_idle = 1'b1, frame_done = 1'b0;

  logic       tx_bit, arb_active, grant_valid, arb_won, arb_lost, bit_err, give_up;
  logic [1:0] grant_idx;
  logic [4:0] retry_cnt;

  logic       tx_bit2, arb_active2, grant_valid2, arb_won2, arb_lost2, bit_err2, give_up2;
  logic [1:0] grant_idx2;
  logic [1:0] retry_cnt2;

  int total = 0;
  int bad   = 0;

  logic [10:0] ids[4];
  logic        rtrs[4];

  always #5 clk = ~clk;

  can_tx_arb_scheduler #(.NUM_MB(4), .ID_W(11), .RETRY_MAX(16)) u_dut (
    .clk(clk), .rst(rst), .req(req), .mb_id(mb_id), .mb_rtr(mb_rtr),
    .sample_point(sample_point), .rx_bit(rx_bit), .bus_idle(bus_idle), .frame_done(frame_done),
    .tx_bit(tx_bit), .arbitration_active(arb_active), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .arb_won(arb_won), .arb_lost(arb_lost), .bit_err(bit_err),
    .give_up(give_up), .retry_cnt(retry_cnt)
  );

  can_tx_arb_scheduler #(.NUM_MB(4), .ID_W(11), .RETRY_MAX(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .mb_id(mb_id), .mb_rtr(mb_rtr),
    .sample_point(sample_point), .rx_bit(rx_bit), .bus_idle(bus_idle), .frame_done(frame_done),
    .tx_bit(tx_bit2), .arbitration_active(arb_active2), .grant_valid(grant_valid2),
    .grant_idx(grant_idx2), .arb_won(arb_won2), .arb_lost(arb_lost2), .bit_err(bit_err2),
    .give_up(give_up2), .retry_cnt(retry_cnt2)
  );

  // Outcome pulses are mutually exclusive in every cycle, for both instances.
  always @(negedge clk) begin
    total++;
    if (!$onehot0({arb_won, arb_lost, bit_err, give_up}) ||
        !$onehot0({arb_won2, arb_lost2, bit_err2, give_up2})) begin
      bad++;
      $display("FAIL pulse_overlap: got %b/%b want at most one high",
               {arb_won, arb_lost, bit_err, give_up}, {arb_won2, arb_lost2, bit_err2, give_up2});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mb(input int i, input logic [10:0] id, input logic r);
    ids[i]          = id;
    rtrs[i]         = r;
    mb_id[i*11 +: 11] = id;
    mb_rtr[i]       = r;
  endtask

  // Reference priority: smallest (id, index) pair among requesters.
  function automatic int model_pick(input logic [3:0] r);
    int best_key = -1;
    int key;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        key = int'(ids[i]) * 16 + i;
        if (best_key < 0 || key < best_key) best_key = key;
      end
    end
    return (best_key < 0) ? -1 : best_key % 16;
  endfunction

  // Arbitration field bit k: 0 = SOF, 1..11 = ID MSB first, 12 = RTR.
  function automatic logic exp_bit(input logic [10:0] id, input logic r, input int k);
    if (k == 0) return 1'b0;
    if (k <= 11) return id[11-k];
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; sample_point = 1'b0; frame_done = 1'b0; rx_bit = 1'b1; bus_idle = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Starts arbitration from WAIT_IDLE and walks the arbitration field.
  // outcome: 0 won, 1 lost, 2 bit error, 3 stopped before sampling stop_k.
  task automatic run_arb(input int exp_idx, input int force_k, input logic force_v,
                         input int exp_retry, input bit chk2, input int stop_k, output int outcome);
    logic eb, rv;
    logic [10:0] eid;
    logic        ertr;
    eid = ids[exp_idx];
    ertr = rtrs[exp_idx];
    outcome = 3;
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
    total++;
    if (arb_active !== 1'b1 || tx_bit !== 1'b0) begin
      bad++;
      $display("FAIL arb_start: got active=%b tx=%b want active=1 tx=0", arb_active, tx_bit);
    end
    for (int k = 0; k < 13; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (k == stop_k) return;
      eb = exp_bit(eid, ertr, k);
      rv = (k == force_k) ? force_v : eb;
      total++;
      if (tx_bit !== eb) begin
        bad++;
        $display("FAIL tx_bit[%0d]: got %b want %b", k, tx_bit, eb);
      end
      sample_point = 1'b1;
      rx_bit = rv;
      tick();
      sample_point = 1'b0;
      rx_bit = 1'b1;
      if (eb == 1'b1 && rv == 1'b0) begin
        total++;
        if (arb_lost !== 1'b1 || tx_bit !== 1'b1 || arb_active !== 1'b0 || int'(retry_cnt) != exp_retry + 1) begin
          bad++;
          $display("FAIL arb_lost: got lost=%b tx=%b active=%b retry=%0d want 1 1 0 %0d",
                   arb_lost, tx_bit, arb_active, retry_cnt, exp_retry + 1);
        end
        if (chk2) begin
          total++;
          if (exp_retry + 1 >= 2) begin
            if (give_up2 !== 1'b1 || arb_lost2 !== 1'b0 || retry_cnt2 !== 2'd0 || arb_active2 !== 1'b0) begin
              bad++;
              $display("FAIL give_up: got give_up=%b lost=%b retry=%0d active=%b want 1 0 0 0",
                       give_up2, arb_lost2, retry_cnt2, arb_active2);
            end
          end else if (arb_lost2 !== 1'b1 || int'(retry_cnt2) != exp_retry + 1) begin
            bad++;
            $display("FAIL lost_dut2: got lost=%b retry=%0d want 1 %0d", arb_lost2, retry_cnt2, exp_retry + 1);
          end
        end
        tick();
        total++;
        if (arb_lost !== 1'b0) begin
          bad++;
          $display("FAIL lost_pulse_width: got %b want 0", arb_lost);
        end
        outcome = 1;
        return;
      end
      if (eb == 1'b0 && rv == 1'b1) begin
        total++;
        if (bit_err !== 1'b1 || tx_bit !== 1'b1 || arb_active !== 1'b0 || int'(retry_cnt) != exp_retry) begin
          bad++;
          $display("FAIL bit_err: got err=%b tx=%b active=%b retry=%0d want 1 1 0 %0d",
                   bit_err, tx_bit, arb_active, retry_cnt, exp_retry);
        end
        tick();
        total++;
        if (bit_err !== 1'b0) begin
          bad++;
          $display("FAIL err_pulse_width: got %b want 0", bit_err);
        end
        outcome = 2;
        return;
      end
      if (k == 12) begin
        total++;
        if (arb_won !== 1'b1 || grant_valid !== 1'b1 || int'(grant_idx) != exp_idx ||
            arb_active !== 1'b0 || tx_bit !== 1'b1) begin
          bad++;
          $display("FAIL arb_won: got won=%b gv=%b idx=%0d active=%b tx=%b want 1 1 %0d 0 1",
                   arb_won, grant_valid, grant_idx, arb_active, tx_bit, exp_idx);
        end
        tick();
        total++;
        if (arb_won !== 1'b0 || grant_valid !== 1'b1) begin
          bad++;
          $display("FAIL granted_hold: got won=%b gv=%b want 0 1", arb_won, grant_valid);
        end
        outcome = 0;
        return;
      end
      total++;
      if (arb_active !== 1'b1 || arb_won !== 1'b0) begin
        bad++;
        $display("FAIL mid_arb[%0d]: got active=%b won=%b want 1 0", k, arb_active, arb_won);
      end
    end
  endtask

  task automatic end_frame(input bit granted);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    if (granted) begin
      total++;
      if (grant_valid !== 1'b0 || retry_cnt !== 5'd0) begin
        bad++;
        $display("FAIL frame_done_release: got gv=%b retry=%0d want 0 0", grant_valid, retry_cnt);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (tx_bit !== 1'b1 || arb_active !== 1'b0 || grant_valid !== 1'b0 || grant_idx !== 2'd0 ||
        {arb_won, arb_lost, bit_err, give_up} !== 4'b0 || retry_cnt !== 5'd0) begin
      bad++;
      $display("FAIL reset_values: got tx=%b act=%b gv=%b idx=%0d pulses=%b retry=%0d want 1 0 0 0 0000 0",
               tx_bit, arb_active, grant_valid, grant_idx, {arb_won, arb_lost, bit_err, give_up}, retry_cnt);
    end
  endtask

  task automatic setup_plan();
    set_mb(0, 11'h7FF, 1'b1);
    set_mb(1, 11'h123, 1'b0);
    set_mb(2, 11'h0F0, 1'b0);
    set_mb(3, 11'h7FF, 1'b1);
    req = 4'b0110;
    repeat (3) tick();
  endtask

  task automatic test_win();
    int o;
    do_reset();
    setup_plan();
    run_arb(model_pick(req), -1, 1'b0, 0, 1'b0, -1, o);
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
    total++;
    if (tx_bit !== 1'b1 || arb_active !== 1'b0 || grant_valid !== 1'b1) begin
      bad++;
      $display("FAIL granted_ignores_sample: got tx=%b act=%b gv=%b want 1 0 1", tx_bit, arb_active, grant_valid);
    end
    end_frame(1'b1);
  endtask

  task automatic test_loss_retry();
    int o;
    do_reset();
    setup_plan();
    run_arb(model_pick(req), 4, 1'b0, 0, 1'b0, -1, o);
    end_frame(1'b0);
    tick();
    run_arb(model_pick(req), -1, 1'b0, 1, 1'b0, -1, o);
    total++;
    if (o != 0 || retry_cnt !== 5'd1) begin
      bad++;
      $display("FAIL retry_win: got outcome=%0d retry=%0d want 0 1", o, retry_cnt);
    end
    end_frame(1'b1);
  endtask

  task automatic test_tie();
    int o;
    do_reset();
    set_mb(0, 11'h300, 1'b0);
    set_mb(1, 11'h050, 1'b0);
    set_mb(2, 11'h7FF, 1'b0);
    set_mb(3, 11'h050, 1'b1);
    req = 4'b1010;
    repeat (3) tick();
    run_arb(model_pick(req), -1, 1'b0, 0, 1'b0, -1, o);
    end_frame(1'b1);
  endtask

  task automatic test_bit_err();
    int o;
    do_reset();
    setup_plan();
    run_arb(model_pick(req), 0, 1'b1, 0, 1'b0, -1, o);
    end_frame(1'b0);
    tick();
    run_arb(model_pick(req), -1, 1'b0, 0, 1'b0, -1, o);
    end_frame(1'b1);
  endtask

  task automatic test_give_up();
    int o;
    do_reset();
    set_mb(0, 11'h400, 1'b0);
    req = 4'b0001;
    repeat (3) tick();
    run_arb(0, 1, 1'b0, 0, 1'b1, -1, o);
    end_frame(1'b0);
    tick();
    run_arb(0, 1, 1'b0, 1, 1'b1, -1, o);
    req = 4'b0000;
    repeat (3) tick();
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
    total++;
    if (arb_active2 !== 1'b0 || grant_valid2 !== 1'b0 || retry_cnt2 !== 2'd0) begin
      bad++;
      $display("FAIL give_up_idle: got act=%b gv=%b retry=%0d want 0 0 0", arb_active2, grant_valid2, retry_cnt2);
    end
  endtask

  task automatic test_rst_mid_arb();
    int o;
    do_reset();
    setup_plan();
    run_arb(model_pick(req), -1, 1'b0, 0, 1'b0, 6, o);
    rst = 1'b1;
    tick();
    total++;
    if (tx_bit !== 1'b1 || arb_active !== 1'b0 || grant_valid !== 1'b0 ||
        {arb_won, arb_lost, bit_err, give_up} !== 4'b0 || retry_cnt !== 5'd0) begin
      bad++;
      $display("FAIL rst_mid_arb: got tx=%b act=%b gv=%b pulses=%b retry=%0d want 1 0 0 0000 0",
               tx_bit, arb_active, grant_valid, {arb_won, arb_lost, bit_err, give_up}, retry_cnt);
    end
    rst = 1'b0;
    repeat (3) tick();
    run_arb(model_pick(req), -1, 1'b0, 0, 1'b0, -1, o);
    end_frame(1'b1);
  endtask

  task automatic test_random();
    int o, pick, fk, retry_exp;
    logic fv;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 4; i++)
        set_mb(i, (it % 2 == 1) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
      req = 4'($urandom_range(1, 15));
      pick = model_pick(req);
      repeat (3) tick();
      retry_exp = 0;
      if ($urandom_range(0, 1) == 1) begin
        fk = $urandom_range(1, 12);
        fv = ~exp_bit(ids[pick], rtrs[pick], fk);
        run_arb(pick, fk, fv, 0, 1'b0, -1, o);
        if (o == 1) retry_exp = 1;
        end_frame(1'b0);
        tick();
      end
      run_arb(pick, -1, 1'b0, retry_exp, 1'b0, -1, o);
      end_frame(1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_loss_retry();
    test_tie();
    test_bit_err();
    test_give_up();
    test_rst_mid_arb();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
